load_store_unit: RTL and testbench

Sub-word access engine between the MIPS MEM-stage control and `dataMemory`. It accepts one load or store request at a time and drives the word-wide `dataMemory` port (`address`, `wrData`, `MemWrite`, `MemRead`, `readData`). Byte and halfword loads are extracted and extended; byte and halfword stores use read-modify-write. It stalls the pipeline through `req_ready` while an access is in flight.

---
 rtl/lsu_pkg.sv | 30 +++
 rtl/lsu_align.sv | 72 +++++++
 rtl/load_store_unit.sv | 112 +++++++++++
 tb/tb_load_store_unit.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: MIPS sub-word opcodes,
// FSM state encoding and big-endian byte offsets.
package lsu_pkg;

   typedef enum logic [3:0] {
      OP_LB  = 4'b0000,
      OP_LH  = 4'b0001,
      OP_LW  = 4'b0011,
      OP_LBU = 4'b0100,
      OP_LHU = 4'b0101,
      OP_SB  = 4'b1000,
      OP_SH  = 4'b1001,
      OP_SW  = 4'b1011
   } mem_op_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD,
      ST_CAP,
      ST_WR,
      ST_DONE
   } lsu_state_t;

   // Big-endian: offset 0 is the most significant byte of the word
   localparam logic [1:0] OFFS_BYTE0 = 2'd0;
   localparam logic [1:0] OFFS_BYTE1 = 2'd1;
   localparam logic [1:0] OFFS_BYTE2 = 2'd2;
   localparam logic [1:0] OFFS_BYTE3 = 2'd3;

endpackage

// File: rtl/lsu_align.sv
// Combinational sub-word steering: load extraction/extension, store merge
// into a read word, and detection of illegal or misaligned requests.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [3:0]  op,
   input  logic [1:0]  addr,
   input  logic [31:0] read_data,
   input  logic [31:0] store_data,
   output logic [31:0] load_word,
   output logic [31:0] store_word,
   output logic        bad
);

   logic [7:0]  byte_val;
   logic [15:0] half_val;

   always_comb begin
      byte_val = 8'h00;
      case (addr)
         OFFS_BYTE0: byte_val = read_data[31:24];
         OFFS_BYTE1: byte_val = read_data[23:16];
         OFFS_BYTE2: byte_val = read_data[15:8];
         OFFS_BYTE3: byte_val = read_data[7:0];
         default:    byte_val = 8'h00;
      endcase
      half_val = addr[1] ? read_data[15:0] : read_data[31:16];
   end

   always_comb begin
      load_word = read_data;
      case (op)
         OP_LB:   load_word = {{24{byte_val[7]}}, byte_val};
         OP_LBU:  load_word = {24'h000000, byte_val};
         OP_LH:   load_word = {{16{half_val[15]}}, half_val};
         OP_LHU:  load_word = {16'h0000, half_val};
         default: load_word = read_data;
      endcase
   end

   // Sub-word stores overwrite only their lane of the word just read back
   always_comb begin
      store_word = read_data;
      case (op)
         OP_SB: begin
            case (addr)
               OFFS_BYTE0: store_word[31:24] = store_data[7:0];
               OFFS_BYTE1: store_word[23:16] = store_data[7:0];
               OFFS_BYTE2: store_word[15:8]  = store_data[7:0];
               OFFS_BYTE3: store_word[7:0]   = store_data[7:0];
               default:    store_word        = read_data;
            endcase
         end
         OP_SH: begin
            if (addr[1]) store_word[15:0]  = store_data[15:0];
            else         store_word[31:16] = store_data[15:0];
         end
         default: store_word = store_data;
      endcase
   end

   always_comb begin
      bad = 1'b1;
      case (op)
         OP_LB, OP_LBU, OP_SB: bad = 1'b0;
         OP_LH, OP_LHU, OP_SH: bad = addr[0];
         OP_LW, OP_SW:         bad = (addr != 2'b00);
         default:              bad = 1'b1;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store engine between MEM-stage control and a
// word-wide data memory; sub-word stores use read-modify-write.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [3:0]        req_op,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              done,
   output logic              fault,
   output logic [DATA_W-1:0] load_data,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_wrData,
   output logic              mem_MemWrite,
   output logic              mem_MemRead,
   input  logic [DATA_W-1:0] mem_readData
);

   lsu_state_t        state, state_next;
   logic [3:0]        op_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              fault_q;

   logic              accept;
   logic [3:0]        sel_op;
   logic [1:0]        sel_addr;
   logic [DATA_W-1:0] ext_word;
   logic [DATA_W-1:0] merged_word;
   logic              req_bad;
   logic              op_is_load;

   assign accept     = (state == ST_IDLE) && req_valid;
   assign op_is_load = ~op_q[3];

   // Fault check uses the live request at accept, the latched one afterwards
   assign sel_op   = (state == ST_IDLE) ? req_op : op_q;
   assign sel_addr = (state == ST_IDLE) ? req_addr[1:0] : addr_q[1:0];

   lsu_align u_align (
      .op         (sel_op),
      .addr       (sel_addr),
      .read_data  (mem_readData),
      .store_data (wdata_q),
      .load_word  (ext_word),
      .store_word (merged_word),
      .bad        (req_bad)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               if (req_bad)               state_next = ST_DONE;
               else if (req_op == OP_SW)  state_next = ST_WR;
               else                       state_next = ST_RD;
            end
         end
         ST_RD:   state_next = ST_CAP;
         ST_CAP:  state_next = op_is_load ? ST_DONE : ST_WR;
         ST_WR:   state_next = ST_DONE;
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      req_ready    = (state == ST_IDLE);
      mem_MemRead  = (state == ST_RD);
      mem_MemWrite = (state == ST_WR);
      done         = (state == ST_DONE);
      fault        = (state == ST_DONE) && fault_q;
      mem_address  = (state == ST_IDLE) ? '0 : {addr_q[ADDR_W-1:2], 2'b00};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         op_q       <= 4'h0;
         addr_q     <= '0;
         wdata_q    <= '0;
         fault_q    <= 1'b0;
         load_data  <= '0;
         mem_wrData <= '0;
      end else begin
         if (accept) begin
            op_q    <= req_op;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            fault_q <= req_bad;
            if (!req_bad && req_op == OP_SW) mem_wrData <= req_wdata;
         end
         if (state == ST_CAP) begin
            if (op_is_load) load_data  <= ext_word;
            else            mem_wrData <= merged_word;
         end
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit against a registered-read word memory.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [3:0]  req_op;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        done;
   logic        fault;
   logic [31:0] load_data;
   logic [31:0] mem_address;
   logic [31:0] mem_wrData;
   logic        mem_MemWrite;
   logic        mem_MemRead;
   logic [31:0] mem_readData;

   logic [31:0] mem_arr [0:63];

   int          total = 0;
   int          bad = 0;
   int          lat, rd_n, wr_n, wr_at, both, done_n;
   logic [31:0] rd_addr, seen_wdata;
   logic        seen_fault;

   load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_op       (req_op),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .done         (done),
      .fault        (fault),
      .load_data    (load_data),
      .mem_address  (mem_address),
      .mem_wrData   (mem_wrData),
      .mem_MemWrite (mem_MemWrite),
      .mem_MemRead  (mem_MemRead),
      .mem_readData (mem_readData)
   );

   always #5 clk = ~clk;

   // Data memory: write on strobe, read data valid the cycle after MemRead
   always @(posedge clk) begin
      if (mem_MemWrite) mem_arr[mem_address[7:2]] <= mem_wrData;
      if (mem_MemRead)  mem_readData <= mem_arr[mem_address[7:2]];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issue one request, scramble inputs after accept, observe until done
   task automatic run_req(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata);
      lat = -1; rd_n = 0; wr_n = 0; wr_at = -1; both = 0;
      rd_addr = 32'hx; seen_wdata = 32'hx; seen_fault = 1'bx;
      @(negedge clk);
      req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
      @(posedge clk);
      #1;
      req_valid = 1'b0; req_op = 4'b1111;
      req_addr = $urandom; req_wdata = $urandom;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (mem_MemRead) begin rd_n++; rd_addr = mem_address; end
         if (mem_MemWrite) begin wr_n++; wr_at = c; seen_wdata = mem_wrData; end
         if (mem_MemRead && mem_MemWrite) both = 1;
         if (done) begin lat = c; seen_fault = fault; break; end
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem_arr[i] = 32'h0;
      mem_arr[4] = 32'h80FF7F01;
      reset = 1'b1; req_valid = 1'b0; req_op = 4'h0; req_addr = 32'h0; req_wdata = 32'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      check("rst_ready", {31'h0, req_ready}, 32'h1);
      check("rst_done", {31'h0, done}, 32'h0);
      check("rst_fault", {31'h0, fault}, 32'h0);
      check("rst_load_data", load_data, 32'h0);
      check("rst_mem_address", mem_address, 32'h0);
      check("rst_wrdata", mem_wrData, 32'h0);
      check("rst_strobes", {30'h0, mem_MemRead, mem_MemWrite}, 32'h0);

      run_req(4'b0000, 32'h10, 32'h0);
      check("lb_lat", 32'(lat), 32'd3);
      check("lb_data", load_data, 32'hFFFFFF80);
      check("lb_rd_n", 32'(rd_n), 32'd1);
      check("lb_rd_addr", rd_addr, 32'h10);
      check("lb_wr_n", 32'(wr_n), 32'd0);
      check("lb_fault", {31'h0, seen_fault}, 32'h0);

      run_req(4'b0100, 32'h11, 32'h0);
      check("lbu_data", load_data, 32'h000000FF);
      run_req(4'b0001, 32'h10, 32'h0);
      check("lh_data", load_data, 32'hFFFF80FF);
      run_req(4'b0101, 32'h12, 32'h0);
      check("lhu_data", load_data, 32'h00007F01);
      check("lhu_lat", 32'(lat), 32'd3);
      run_req(4'b0011, 32'h10, 32'h0);
      check("lw_data", load_data, 32'h80FF7F01);

      run_req(4'b1000, 32'h13, 32'h000000AB);
      check("sb_lat", 32'(lat), 32'd4);
      check("sb_rd_n", 32'(rd_n), 32'd1);
      check("sb_rd_addr", rd_addr, 32'h10);
      check("sb_wr_n", 32'(wr_n), 32'd1);
      check("sb_wrdata", seen_wdata, 32'h80FF7FAB);
      check("sb_overlap", 32'(both), 32'd0);
      run_req(4'b0011, 32'h10, 32'h0);
      check("lw_after_sb", load_data, 32'h80FF7FAB);

      run_req(4'b1001, 32'h10, 32'h00001234);
      check("sh_lat", 32'(lat), 32'd4);
      check("sh_wrdata", seen_wdata, 32'h12347FAB);

      run_req(4'b1011, 32'h20, 32'h10101010);
      check("sw_rd_n", 32'(rd_n), 32'd0);
      check("sw_wr_at", 32'(wr_at), 32'd1);
      check("sw_lat", 32'(lat), 32'd2);
      check("sw_wrdata", seen_wdata, 32'h10101010);
      run_req(4'b0011, 32'h20, 32'h0);
      check("lw_after_sw", load_data, 32'h10101010);

      run_req(4'b0011, 32'h22, 32'h0);
      check("f_lw_lat", 32'(lat), 32'd1);
      check("f_lw_fault", {31'h0, seen_fault}, 32'h1);
      check("f_lw_strobes", 32'(rd_n + wr_n), 32'd0);
      run_req(4'b1001, 32'h13, 32'h5555);
      check("f_sh_lat", 32'(lat), 32'd1);
      check("f_sh_fault", {31'h0, seen_fault}, 32'h1);
      check("f_sh_strobes", 32'(rd_n + wr_n), 32'd0);
      run_req(4'b0111, 32'h10, 32'h0);
      check("f_op_lat", 32'(lat), 32'd1);
      check("f_op_fault", {31'h0, seen_fault}, 32'h1);
      check("f_op_strobes", 32'(rd_n + wr_n), 32'd0);
      check("load_hold", load_data, 32'h10101010);

      // SB of 0xCD into byte 1 of word 0x20, reset while the write is on the bus
      @(negedge clk);
      req_valid = 1'b1; req_op = 4'b1000; req_addr = 32'h21; req_wdata = 32'h000000CD;
      @(posedge clk);
      #1 req_valid = 1'b0;
      wr_at = -1;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (mem_MemWrite) begin wr_at = c; break; end
      end
      check("rst_wr_seen", 32'(wr_at), 32'd3);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("mid_rst_strobes", {30'h0, mem_MemRead, mem_MemWrite}, 32'h0);
      check("mid_rst_ready", {31'h0, req_ready}, 32'h1);
      check("mid_rst_done", {31'h0, done}, 32'h0);
      done_n = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (done || mem_MemWrite) done_n++;
      end
      check("mid_rst_quiet", 32'(done_n), 32'd0);
      check("mid_rst_write", mem_arr[8], 32'h10CD1010);

      run_req(4'b0000, 32'h21, 32'h0);
      check("lb_after_rst_lat", 32'(lat), 32'd3);
      check("lb_after_rst", load_data, 32'hFFFFFFCD);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
